matmul_engine: RTL and testbench

- Parametrised sequential unsigned matrix multiplier: computes R = A x B for square M_SIZE x M_SIZE matrices of VAR_WIDTH-bit elements, one multiply-accumulate per clock.
- Operands are captured on a start handshake, so the inputs may change while the block is computing.
- Output mode is selectable per operation: wrap (keep the low bits) or saturate. Overflow is reported.
- Sits in the same compute datapath slot as the existing fixed 2x2 multiplier and replaces it in new designs.

---
 rtl/matmul_engine.sv | 93 +++++++++
 tb/tb_matmul_engine.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// matmul_engine: sequential unsigned square matrix multiplier, one MAC per clock, wrap or saturate output
module matmul_engine #(
  parameter int VAR_WIDTH = 4,
  parameter int M_SIZE = 2,
  parameter int ACC_WIDTH = 2*VAR_WIDTH+$clog2(M_SIZE)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sat_mode,
  input  logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0] matrixA,
  input  logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0] matrixB,
  output logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0] result,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int N = VAR_WIDTH*M_SIZE*M_SIZE;
  localparam int IW = $clog2(M_SIZE);
  localparam logic [IW-1:0] LAST = IW'(M_SIZE-1);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state, nxt;
  logic [N-1:0] a_q, b_q, stage, stage_w;
  logic sat_q, run_ov, big, row_end, last;
  logic [IW-1:0] i, j, k;
  logic [ACC_WIDTH-1:0] acc, sum;
  logic [VAR_WIDTH-1:0] ae, be, elem;
  logic [2*VAR_WIDTH-1:0] prod;
  // multiply-accumulate datapath and the staging image with the current element merged in
  always_comb begin
    ae = a_q[VAR_WIDTH*(int'(i)*M_SIZE+int'(k)) +: VAR_WIDTH];
    be = b_q[VAR_WIDTH*(int'(k)*M_SIZE+int'(j)) +: VAR_WIDTH];
    prod = {{VAR_WIDTH{1'b0}}, ae} * {{VAR_WIDTH{1'b0}}, be};
    sum = acc + ACC_WIDTH'(prod);
    big = |sum[ACC_WIDTH-1:VAR_WIDTH];
    elem = (sat_q && big) ? '1 : sum[VAR_WIDTH-1:0];
    stage_w = stage;
    stage_w[VAR_WIDTH*(int'(i)*M_SIZE+int'(j)) +: VAR_WIDTH] = elem;
    row_end = k == LAST;
    last = row_end && j == LAST && i == LAST;
  end
  // next state and status outputs; DONE and the unused encoding fall back to IDLE
  always_comb begin
    nxt = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
    busy = state == CALC;
    done = state == DONE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // operand capture, index walk, accumulation and publication of the finished matrix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sat_q <= 1'b0;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      run_ov <= 1'b0;
      stage <= '0;
      result <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_q <= matrixA;
      b_q <= matrixB;
      sat_q <= sat_mode;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      run_ov <= 1'b0;
    end else if (state == CALC) begin
      if (!row_end) begin
        acc <= sum;
        k <= k + 1'b1;
      end else begin
        stage <= stage_w;
        acc <= '0;
        k <= '0;
        run_ov <= run_ov | big;
        j <= j == LAST ? '0 : j + 1'b1;
        if (j == LAST) i <= i == LAST ? '0 : i + 1'b1;
        if (last) begin
          result <= stage_w;
          overflow <= run_ov | big;
        end
      end
    end
  end
endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed and random checks of matmul_engine with a result scoreboard
module tb_matmul_engine;
  logic clk = 1'b0;
  logic rst;
  logic start2, sat2, busy2, done2, overflow2;
  logic [15:0] a2, b2, result2;
  logic start3, sat3, busy3, done3, overflow3;
  logic [71:0] a3, b3, result3;
  logic [72:0] sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_engine u2 (
    .clk(clk), .rst(rst), .start(start2), .sat_mode(sat2),
    .matrixA(a2), .matrixB(b2), .result(result2),
    .busy(busy2), .done(done2), .overflow(overflow2)
  );

  matmul_engine #(.VAR_WIDTH(8), .M_SIZE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .sat_mode(sat3),
    .matrixA(a3), .matrixB(b3), .result(result3),
    .busy(busy3), .done(done3), .overflow(overflow3)
  );

  task automatic chk(string tag, logic [72:0] obs, logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] pk2(logic ov, logic [15:0] r);
    return {ov, 56'b0, r};
  endfunction

  function automatic logic [72:0] model2(logic [15:0] a, logic [15:0] b, logic sat);
    logic [15:0] res = '0;
    logic ov = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int s = 0;
        logic [3:0] e;
        for (int m = 0; m < 2; m++) s += int'(a[4*(r*2+m) +: 4]) * int'(b[4*(m*2+c) +: 4]);
        e = (s > 15 && sat) ? 4'hF : 4'(s);
        ov |= s > 15;
        res[4*(r*2+c) +: 4] = e;
      end
    return pk2(ov, res);
  endfunction

  task automatic run_op(string tag, bit sel, logic [71:0] a, logic [71:0] b, logic sat, logic [72:0] exp, int poke);
    int n, nb, lat;
    logic got;
    lat = sel ? 27 : 8;
    sb.push_back(exp);
    @(negedge clk);
    if (sel) begin a3 = a; b3 = b; sat3 = sat; start3 = 1'b1; end
    else begin a2 = a[15:0]; b2 = b[15:0]; sat2 = sat; start2 = 1'b1; end
    n = 0;
    nb = 0;
    got = 1'b0;
    while (!got && n < lat + 10) begin
      @(negedge clk);
      n++;
      start2 = 1'b0;
      start3 = 1'b0;
      if (n == poke) begin
        a2 = ~a2; b2 = ~b2; sat2 = ~sat2; start2 = !sel;
        a3 = ~a3; start3 = sel;
      end
      got = sel ? done3 : done2;
      if (!got && (sel ? busy3 : busy2)) nb++;
    end
    start2 = 1'b0;
    start3 = 1'b0;
    chk({tag, ":done"}, 73'(got), 73'(1));
    chk({tag, ":latency"}, 73'(n - 1), 73'(lat));
    chk({tag, ":busy_cycles"}, 73'(nb), 73'(lat));
    chk({tag, ":busy_at_done"}, 73'(sel ? busy3 : busy2), 73'(0));
    chk({tag, ":result"}, sel ? {overflow3, result3} : pk2(overflow2, result2), sb.pop_front());
    @(negedge clk);
    chk({tag, ":done_width"}, 73'(sel ? done3 : done2), 73'(0));
  endtask

  initial begin
    logic [71:0] id3, seq3;
    logic [15:0] ra, rb;
    logic rs;
    int pulses;
    rst = 1'b1;
    start2 = 1'b0; sat2 = 1'b0; a2 = '0; b2 = '0;
    start3 = 1'b0; sat3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    chk("reset u2", 73'({result2, busy2, done2, overflow2}), 73'(0));
    chk("reset u3", 73'({result3, busy3, done3, overflow3}), 73'(0));
    rst = 1'b0;

    run_op("wrap basic", 0, 72'h4321, 72'h8765, 1'b0, pk2(1'b1, 16'h2B63), 0);
    run_op("sat basic", 0, 72'h4321, 72'h8765, 1'b1, pk2(1'b1, 16'hFFFF), 0);
    run_op("ident wrap", 0, 72'h1001, 72'h4321, 1'b0, pk2(1'b0, 16'h4321), 0);
    run_op("ident sat", 0, 72'h1001, 72'h4321, 1'b1, pk2(1'b0, 16'h4321), 0);
    run_op("max wrap", 0, 72'hFFFF, 72'hFFFF, 1'b0, pk2(1'b1, 16'h2222), 0);
    run_op("max sat", 0, 72'hFFFF, 72'hFFFF, 1'b1, pk2(1'b1, 16'hFFFF), 0);

    run_op("poke mid calc", 0, 72'h4321, 72'h8765, 1'b0, pk2(1'b1, 16'h2B63), 3);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done2) pulses++;
    end
    chk("no queued op", 73'(pulses), 73'(0));
    chk("result held", pk2(overflow2, result2), pk2(1'b1, 16'h2B63));

    @(negedge clk);
    a2 = 16'h4321; b2 = 16'h8765; sat2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort outputs", 73'({result2, busy2, done2, overflow2}), 73'(0));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done2 || busy2) pulses++;
    end
    chk("abort no done", 73'(pulses), 73'(0));
    run_op("after abort", 0, 72'h1001, 72'h4321, 1'b0, pk2(1'b0, 16'h4321), 0);

    for (int t = 0; t < 4; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op("random", 0, 72'(ra), 72'(rb), rs, model2(ra, rb, rs), 0);
    end

    for (int e = 0; e < 9; e++) begin
      id3[8*e +: 8] = (e % 4 == 0) ? 8'd1 : 8'd0;
      seq3[8*e +: 8] = 8'(e + 1);
    end
    run_op("3x3 ident", 1, id3, seq3, 1'b0, {1'b0, seq3}, 0);
    run_op("3x3 max sat", 1, '1, '1, 1'b1, {1'b1, {72{1'b1}}}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
